// File: rtl/aes_arb_pkg.sv
// Shared constants and types for the two-requester AES arbiter.
package aes_arb_pkg;

  // Data width of one AES block (plaintext, key and ciphertext).
  localparam int AES_BLK_W = 128;

  // Default core latency, from the core_valid pulse to a valid core_ctxt.
  localparam int AES_DEF_LATENCY = 12;

  // This revision supports exactly two requesters.
  localparam int AES_NREQ = 2;

  // Controller states. Only one operation is outstanding at a time.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Convert a requester index into its one-hot select vector.
  function automatic logic [AES_NREQ-1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational two-way round-robin choice. On a tie the requester that was
// not served last wins; a lone requester always wins.
module aes_rr_pick
  import aes_arb_pkg::*;
(
  input  logic [AES_NREQ-1:0] req_valid,
  input  logic                rr_last,
  output logic                any,
  output logic                pick
);

  // Pick the winning requester index from the current request vector.
  always_comb begin
    any  = |req_valid;
    pick = 1'b0;
    case (req_valid)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~rr_last;
      default: pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Two-requester front end for a fixed-latency AES core. One operation is in
// flight at a time: accept (IDLE) -> start pulse (ISSUE) -> count down the
// core latency (WAIT) -> hold the ciphertext for the owner (RESP).
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int LATENCY = AES_DEF_LATENCY,
  parameter int NREQ    = AES_NREQ
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [AES_BLK_W-1:0] req_ptxt0,
  input  logic [AES_BLK_W-1:0] req_ptxt1,
  input  logic [AES_BLK_W-1:0] req_key0,
  input  logic [AES_BLK_W-1:0] req_key1,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [AES_BLK_W-1:0] rsp_ctxt,
  output logic                 core_valid,
  output logic [AES_BLK_W-1:0] core_ptxt,
  output logic [AES_BLK_W-1:0] core_key,
  input  logic [AES_BLK_W-1:0] core_ctxt,
  output logic                 busy,
  output logic                 grant_id
);

  // The counter must hold LATENCY-1; keep at least one bit.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  if (NREQ != 2) begin : g_nreq_check
    $error("aes_req_arbiter supports exactly two requesters");
  end
  if (LATENCY < 1) begin : g_lat_check
    $error("aes_req_arbiter needs LATENCY of at least 1");
  end

  arb_state_t           state;
  logic                 rr_last;
  logic [CNT_W-1:0]     cnt;
  logic [AES_BLK_W-1:0] opnd_ptxt;
  logic [AES_BLK_W-1:0] opnd_key;
  logic [AES_BLK_W-1:0] result;

  logic any;
  logic pick;
  logic accept;
  logic wait_done;
  logic rsp_done;

  aes_rr_pick u_pick (
    .req_valid (req_valid),
    .rr_last   (rr_last),
    .any       (any),
    .pick      (pick)
  );

  // Decode handshakes from the current state; requests only count in IDLE and
  // the owner's rsp_ready is the only one that can close a response.
  always_comb begin
    accept    = (state == ST_IDLE) && any;
    wait_done = (state == ST_WAIT) && (cnt == '0);
    rsp_done  = (state == ST_RESP) && rsp_ready[grant_id];
  end

  // Drive the handshake and core-facing outputs. req_ready is also gated by
  // rst so it drops the moment reset asserts, not just on the next edge.
  always_comb begin
    req_ready  = (accept && rst) ? req_onehot(pick) : '0;
    rsp_valid  = (state == ST_RESP) ? req_onehot(grant_id) : '0;
    rsp_ctxt   = result;
    core_valid = (state == ST_ISSUE);
    core_ptxt  = opnd_ptxt;
    core_key   = opnd_key;
    busy       = (state != ST_IDLE);
  end

  // Sequence the controller and keep the round-robin history; rr_last starts
  // at 1 so requester 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      grant_id <= 1'b0;
      rr_last  <= 1'b1;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            grant_id <= pick;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= CNT_LOAD;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_done) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_done) begin
            rr_last <= grant_id;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture the winner's operands on accept and the core result at the end
  // of WAIT; both stay put until the next operation so the core and the
  // requester see stable values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opnd_ptxt <= '0;
      opnd_key  <= '0;
      result    <= '0;
    end else begin
      if (accept) begin
        opnd_ptxt <= pick ? req_ptxt1 : req_ptxt0;
        opnd_key  <= pick ? req_key1  : req_key0;
      end
      if (wait_done) begin
        result <= core_ctxt;
      end
    end
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a fixed-latency core model that
// answers the FIPS-197 known-answer vectors.
module tb_aes_req_arbiter;

  localparam int LAT = 12;

  localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_ptxt0, req_ptxt1, req_key0, req_key1;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [127:0] rsp_ctxt;
  logic         core_valid;
  logic [127:0] core_ptxt, core_key;
  logic [127:0] core_ctxt;
  logic         busy;
  logic         grant_id;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_issue = 0;
  int prev_issue = 0;

  int           mcnt = 0;
  logic [127:0] mres = '0;

  aes_req_arbiter #(.LATENCY(LAT), .NREQ(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ptxt0  (req_ptxt0),
    .req_ptxt1  (req_ptxt1),
    .req_key0   (req_key0),
    .req_key1   (req_key1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_ctxt   (rsp_ctxt),
    .core_valid (core_valid),
    .core_ptxt  (core_ptxt),
    .core_key   (core_key),
    .core_ctxt  (core_ctxt),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Known-answer lookup standing in for the cipher; unknown operands get a
  // recognisable stand-in value.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == KA && p == PA) return CA;
    if (k == KB && p == PB) return CB;
    return k ^ p;
  endfunction

  // Core model: result appears on core_ctxt LAT cycles after the start pulse,
  // with junk on the bus until then.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_valid === 1'b1) begin
      mcnt      <= LAT - 1;
      mres      <= core_fn(core_key, core_ptxt);
      core_ctxt <= JUNK;
    end else if (mcnt == 1) begin
      core_ctxt <= mres;
      mcnt      <= 0;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end
  end

  always @(negedge clk) begin
    if (core_valid === 1'b1) begin
      prev_issue = last_issue;
      last_issue = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Called on the accept cycle; follows the operation up to its first RESP
  // cycle, checking latency, a single start pulse and stable operands.
  task automatic wait_rsp(input string tag, input logic [1:0] rv_after,
                          input logic [1:0] ev, input logic [127:0] ec,
                          input logic [127:0] ep, input logic [127:0] ek);
    int n;
    int ncv;
    bit ok;
    n = 0;
    ncv = 0;
    ok = 1'b1;
    while (rsp_valid === 2'b00 && n < 40) begin
      @(negedge clk);
      if (n == 0) req_valid = rv_after;
      #1;
      n++;
      if (core_valid === 1'b1) ncv++;
      if (rsp_valid === 2'b00) begin
        if (core_ptxt !== ep || core_key !== ek || req_ready !== 2'b00 || busy !== 1'b1)
          ok = 1'b0;
      end
    end
    chk({tag, "_lat"}, 128'(n), 128'd14);
    chk({tag, "_pulses"}, 128'(ncv), 128'd1);
    chk({tag, "_stable"}, 128'(ok), 128'd1);
    chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(ev));
    chk({tag, "_rsp_ctxt"}, rsp_ctxt, ec);
  endtask

  initial begin
    bit ok;
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_ptxt0 = '0;
    req_ptxt1 = '0;
    req_key0 = '0;
    req_key1 = '0;
    core_ctxt = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_core_valid", 128'(core_valid), 128'd0);
    chk("rst_grant", 128'(grant_id), 128'd0);
    chk("rst_core_ptxt", core_ptxt, 128'd0);
    chk("rst_rsp_ctxt", rsp_ctxt, 128'd0);
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", 128'(req_ready), 128'd0);
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b1;

    // Requester 0 alone, withdrawn right after accept
    @(negedge clk);
    req_key0 = KA; req_ptxt0 = PA;
    req_key1 = KB; req_ptxt1 = PB;
    req_valid = 2'b01;
    #1;
    chk("t1_ready", 128'(req_ready), 128'b01);
    wait_rsp("t1", 2'b00, 2'b01, CA, PA, KA);
    chk("t1_grant", 128'(grant_id), 128'd0);
    rsp_ready = 2'b01;
    @(negedge clk); #1;
    chk("t1_done_busy", 128'(busy), 128'd0);
    chk("t1_done_rsp", 128'(rsp_valid), 128'd0);
    rsp_ready = 2'b00;

    // Both valid from reset: 0, then 1, then 0 again
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("t2_tie0", 128'(req_ready), 128'b01);
    wait_rsp("t2a", 2'b11, 2'b01, CA, PA, KA);
    chk("t2_resp_noready", 128'(req_ready), 128'd0);
    rsp_ready = 2'b01;
    @(negedge clk); #1;
    chk("t2_tie1", 128'(req_ready), 128'b10);
    chk("t2_idle", 128'(busy), 128'd0);
    wait_rsp("t2b", 2'b11, 2'b10, CB, PB, KB);
    chk("t2_grant1", 128'(grant_id), 128'd1);
    @(negedge clk); #1;
    chk("t2_ignore_rdy", 128'(rsp_valid), 128'b10);
    rsp_ready = 2'b10;
    @(negedge clk); #1;
    chk("t2_tie_again", 128'(req_ready), 128'b01);
    rsp_ready = 2'b00;

    // Response held for 20 cycles with requests pending
    wait_rsp("t3", 2'b00, 2'b01, CA, PA, KA);
    req_valid = 2'b11;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk); #1;
      if (rsp_valid !== 2'b01 || rsp_ctxt !== CA || req_ready !== 2'b00 ||
          core_valid !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    chk("t3_hold", 128'(ok), 128'd1);
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    @(negedge clk); #1;
    chk("t3_released", 128'(busy), 128'd0);
    rsp_ready = 2'b00;

    // Reset during WAIT at count 5
    req_valid = 2'b10;
    #1;
    chk("t4_ready", 128'(req_ready), 128'b10);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (7) @(negedge clk);
    #1;
    chk("t4_pre_busy", 128'(busy), 128'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("t4_busy", 128'(busy), 128'd0);
    chk("t4_core_valid", 128'(core_valid), 128'd0);
    chk("t4_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("t4_grant", 128'(grant_id), 128'd0);
    chk("t4_core_ptxt", core_ptxt, 128'd0);
    chk("t4_core_key", core_key, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk); #1;
      if (rsp_valid !== 2'b00 || busy !== 1'b0 || core_valid !== 1'b0) ok = 1'b0;
    end
    chk("t4_quiet", 128'(ok), 128'd1);
    req_valid = 2'b11;
    #1;
    chk("t4_tie0", 128'(req_ready), 128'b01);
    wait_rsp("t4b", 2'b00, 2'b01, CA, PA, KA);

    // Back-to-back request at the response handshake
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    #1;
    chk("t5_resp_noaccept", 128'(req_ready), 128'd0);
    @(negedge clk); #1;
    chk("t5_bubble_busy", 128'(busy), 128'd0);
    chk("t5_bubble_ready", 128'(req_ready), 128'b10);
    rsp_ready = 2'b10;
    wait_rsp("t5", 2'b00, 2'b10, CB, PB, KB);
    chk("t5_spacing", 128'(last_issue - prev_issue), 128'(LAT + 3));
    @(negedge clk); #1;
    chk("t5_one_resp", 128'(rsp_valid), 128'd0);
    chk("t5_idle", 128'(busy), 128'd0);
    rsp_ready = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_req_arbiter.md
AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 Parameter LATENCY, default 12, cycles from core_valid high to core_ctxt valid.
REQ-002 Parameter NREQ, default 2, number of requesters; fixed at 2 in this revision.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  [1:0]  per-requester encrypt request.
REQ-006 req_ready  output  [1:0]  per-requester accept; transfer when valid&ready.
REQ-007 req_ptxt0/req_ptxt1  input  128 each  plaintext per requester.
REQ-008 req_key0/req_key1  input  128 each  key per requester.
REQ-009 rsp_valid  output  [1:0]  ciphertext available to the owning requester.
REQ-010 rsp_ready  input  [1:0]  requester accepts response.
REQ-011 rsp_ctxt  output  128  ciphertext, shared by both requesters and qualified by rsp_valid.
REQ-012 core_valid  output  1  start pulse to AES core.
REQ-013 core_ptxt/core_key  output  128 each  operands to core.
REQ-014 core_ctxt  input  128  core result.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 grant_id  output  1  index of the current or last-granted requester.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, and only one operation SHALL be outstanding at a time.
REQ-018 In IDLE, when any req_valid bit is set, the block SHALL grant one requester and assert req_ready for that requester only, combinationally in the same cycle.
REQ-019 Arbitration SHALL be round-robin: if both requesters are valid, the requester not in rr_last wins; a single valid requester always wins.
REQ-020 On accept, the block SHALL latch ptxt/key into operand registers, set grant_id, and go to ISSUE.
REQ-021 ISSUE SHALL last exactly 1 cycle with core_valid=1, load the latency counter with LATENCY-1, and go to WAIT.
REQ-022 core_ptxt/core_key SHALL equal the operand registers and stay stable from ISSUE until leaving WAIT.
REQ-023 WAIT SHALL decrement the counter each cycle; at count 0 it SHALL capture core_ctxt into the result register and go to RESP.
REQ-024 In RESP, rsp_valid[grant_id] SHALL be 1 and rsp_ctxt SHALL hold the result register; the other rsp_valid bit SHALL be 0.
REQ-025 On rsp_valid&rsp_ready for grant_id, the block SHALL set rr_last=grant_id and go to IDLE; rsp_ready on the non-granted bit SHALL be ignored.
REQ-026 A request arriving in the same cycle as the response handshake SHALL be evaluated in the following IDLE cycle (one bubble).
REQ-027 req_valid SHALL be ignored outside IDLE, and req_ready SHALL be 0 outside IDLE.
REQ-028 Minimum issue-to-issue spacing SHALL be LATENCY+3 cycles.
REQ-029 Withdrawal of req_valid after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-030 On rst low, the block SHALL immediately reset: state=IDLE; req_ready, rsp_valid, core_valid and busy =0; grant_id=0; rr_last=1 (requester 0 wins the first tie); counter, operand and result registers =0.
REQ-031 Reset mid-operation SHALL discard the in-flight result; no rsp_valid SHALL follow reset release until a new request is accepted.

Structure
REQ-032 Package aes_arb_pkg SHALL hold the state enum, the default LATENCY, NREQ, and the 128-bit block width constant.
REQ-033 Sub-module aes_rr_pick SHALL implement the combinational 2-way round-robin choice from (req_valid, rr_last).

Verification
REQ-034 Req0 alone with key 000102030405060708090a0b0c0d0e0f and pt 00112233445566778899aabbccddeeff, core model latency 12 -> rsp_valid[0] exactly 14 cycles after accept with rsp_ctxt 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-035 Both requesters valid from reset, req1 carrying key 2b7e151628aed2a6abf7158809cf4f3c and pt 3243f6a8885a308d313198a2e0370734 -> req0 served first, then req1 receives 3925841d02dc09fbdc118597196a0b32, then the next tie goes to req0.
REQ-036 rsp_ready held low for 20 cycles in RESP -> rsp_valid and rsp_ctxt stable, req_ready stays 0, core_valid stays 0.
REQ-037 rst pulsed low during WAIT at count 5 -> all outputs 0 asynchronously, no response after release, and a subsequent request completes correctly.
REQ-038 Back-to-back request at the response handshake, with ready asserted on the response cycle -> exactly one idle bubble before the next accept, core_valid pulsed exactly once per operation, and operand outputs constant during WAIT.
